// File: rtl/ram_stream_reader_if.sv
// Byte stream from the buffer reader to the UART transmitter.
// The master offers TX_DATA with TX_VALID; a byte moves on any rising
// clock edge where TX_VALID and TX_READY are both high.
interface ram_stream_reader_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/ram_stream_reader.sv
// Read side of the uart_mirror byte buffer.
// Drains committed bytes from the asynchronous-read RAM, offers them on a
// valid/ready stream and hands the read pointer back to the writer so it
// can detect a full buffer. Pointers carry one extra wrap bit, so
// LEVEL == depth (full) and LEVEL == 0 (empty) are distinguishable.
module ram_stream_reader #(
  parameter int addr_width = 9,
  parameter int data_width = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [addr_width:0]   WR_PTR,
  output logic [addr_width:0]   RD_PTR,
  output logic [addr_width-1:0] RD_ADDR,
  input  logic [data_width-1:0] RD_DATA,
  input  logic                  PAUSE,
  input  logic                  FLUSH,
  ram_stream_reader_if.master   tx,
  output logic [addr_width:0]   LEVEL,
  output logic                  EMPTY
);

  localparam logic [addr_width:0] ptr_one = {{addr_width{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width:0]   rd_ptr_q, rd_ptr_d;
  logic [data_width-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  handshake;
  logic                  can_load;

  // Occupancy is the modular pointer distance; it wraps naturally at 2^(addr_width+1).
  assign LEVEL  = WR_PTR - rd_ptr_q;
  assign EMPTY  = (LEVEL == '0);

  assign RD_PTR      = rd_ptr_q;
  assign RD_ADDR     = rd_ptr_q[addr_width-1:0];
  assign tx.TX_DATA  = tx_data_q;
  assign tx.TX_VALID = tx_valid_q;

  assign handshake = tx_valid_q & tx.TX_READY;
  // A new byte is fetched only when one is committed and nothing asks us to hold or discard.
  assign can_load  = !EMPTY && !PAUSE && !FLUSH && !flush_pend_q;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions: load, hold, flush or return to IDLE.
  always_comb begin
    // NOTE: every variable gets a default first; without it a path that
    // skips an assignment would infer a latch.
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      IDLE: begin
        if (FLUSH || flush_pend_q) begin
          // Discard everything committed so far, including a byte committed this cycle.
          rd_ptr_d     = WR_PTR;
          flush_pend_d = 1'b0;
        end else if (can_load) begin
          tx_data_d  = RD_DATA;
          rd_ptr_d   = rd_ptr_q + ptr_one;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end

      SEND: begin
        // The offered byte is never retracted; a flush waits until it is taken.
        if (FLUSH) begin
          flush_pend_d = 1'b1;
        end
        if (handshake) begin
          if (can_load) begin
            // Back-to-back: the next byte replaces the accepted one on the same edge.
            tx_data_d = RD_DATA;
            rd_ptr_d  = rd_ptr_q + ptr_one;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops TX_VALID at once, losing any in-flight byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_q     <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a 512-byte RAM with combinational read, a
// queue of bytes the writer has committed and the transmitter should see,
// and directed plus random steps driven from one initial block.
module tb_ram_stream_reader;

  localparam int aw    = 9;
  localparam int dw    = 8;
  localparam int depth = 1 << aw;

  logic          CLK;
  logic          RST_N;
  logic [aw:0]   WR_PTR;
  logic [aw:0]   RD_PTR;
  logic [aw-1:0] RD_ADDR;
  logic [dw-1:0] RD_DATA;
  logic          PAUSE;
  logic          FLUSH;
  logic [aw:0]   LEVEL;
  logic          EMPTY;

  ram_stream_reader_if #(.data_width(dw)) tx ();

  ram_stream_reader #(.addr_width(aw), .data_width(dw)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .WR_PTR  (WR_PTR),
    .RD_PTR  (RD_PTR),
    .RD_ADDR (RD_ADDR),
    .RD_DATA (RD_DATA),
    .PAUSE   (PAUSE),
    .FLUSH   (FLUSH),
    .tx      (tx),
    .LEVEL   (LEVEL),
    .EMPTY   (EMPTY)
  );

  // Buffer RAM with asynchronous read port.
  logic [dw-1:0] mem [depth];
  assign RD_DATA = mem[RD_ADDR];

  // Reference model: bytes committed but not yet accepted, in write order.
  logic [dw-1:0] exp_q [$];
  logic [aw-1:0] addr_log [$];
  bit            log_en;
  bit            prev_stall;
  logic [dw-1:0] prev_data;

  int n_tests;
  int n_fail;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_val(input logic [dw-1:0] v);
    mem[WR_PTR[aw-1:0]] = v;
    exp_q.push_back(v);
    WR_PTR = WR_PTR + (aw+1)'(1);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_val(dw'($urandom));
  endtask

  // One clock cycle: sample just after the falling edge, then advance to the next falling edge.
  task automatic tick();
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(tx.TX_VALID), 1);
      check("hold_data", 32'(tx.TX_DATA), 32'(prev_data));
    end
    if (log_en && (addr_log.size() == 0 || addr_log[$] != RD_ADDR)) addr_log.push_back(RD_ADDR);
    if (tx.TX_VALID === 1'b1 && tx.TX_READY === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_byte", 32'(tx.TX_VALID), 0);
      else check("byte", 32'(tx.TX_DATA), 32'(exp_q.pop_front()));
    end
    prev_stall = (tx.TX_VALID === 1'b1) && (tx.TX_READY !== 1'b1);
    prev_data  = tx.TX_DATA;
    @(negedge CLK);
  endtask

  // Deliver every expected byte within a cycle budget, then confirm the reader is idle and caught up.
  task automatic drain(input int budget, input bit rand_ready);
    int n;
    n = 0;
    PAUSE = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      tx.TX_READY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
    tx.TX_READY = 1'b1;
    tick();
    tick();
    check("drain_empty", 32'(EMPTY), 1);
    check("drain_valid", 32'(tx.TX_VALID), 0);
    check("drain_rd_ptr", 32'(RD_PTR), 32'(WR_PTR));
  endtask

  initial begin
    logic [dw-1:0] keep;
    logic [aw-1:0] e_addr;
    int            k;
    n_tests     = 0;
    n_fail      = 0;
    log_en      = 1'b0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    RST_N       = 1'b0;
    WR_PTR      = '0;
    PAUSE       = 1'b0;
    FLUSH       = 1'b0;
    tx.TX_READY = 1'b0;

    // Reset state.
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rst_valid", 32'(tx.TX_VALID), 0);
    check("rst_rd_ptr", 32'(RD_PTR), 0);
    check("rst_empty", 32'(EMPTY), 1);
    check("rst_level", 32'(LEVEL), 0);
    @(negedge CLK);

    // Reset asserted while a byte is offered.
    push_val(8'hA5);
    push_val(8'h5A);
    tick();
    tick();
    check("mid_valid", 32'(tx.TX_VALID), 1);
    check("mid_data", 32'(tx.TX_DATA), 32'h A5);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_valid", 32'(tx.TX_VALID), 0);
    check("async_rd_ptr", 32'(RD_PTR), 0);
    WR_PTR = '0;
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("rel_empty", 32'(EMPTY), 1);
    check("rel_level", 32'(LEVEL), 0);
    @(negedge CLK);

    // Single byte with the transmitter ready.
    tx.TX_READY = 1'b1;
    push_val(8'h41);
    tick();
    check("single_valid", 32'(tx.TX_VALID), 1);
    check("single_data", 32'(tx.TX_DATA), 32'h41);
    tick();
    check("single_rd_ptr", 32'(RD_PTR), 1);
    check("single_empty", 32'(EMPTY), 1);
    check("single_done", 32'(tx.TX_VALID), 0);

    // Backpressure then back-to-back delivery.
    tx.TX_READY = 1'b0;
    push_val(8'h10);
    push_val(8'h11);
    push_val(8'h12);
    repeat (5) tick();
    check("bp_data", 32'(tx.TX_DATA), 32'h10);
    check("bp_rd_ptr", 32'(RD_PTR), 32'(WR_PTR - (aw+1)'(2)));
    tx.TX_READY = 1'b1;
    tick();
    check("b2b_valid1", 32'(tx.TX_VALID), 1);
    check("b2b_data1", 32'(tx.TX_DATA), 32'h11);
    tick();
    check("b2b_valid2", 32'(tx.TX_VALID), 1);
    check("b2b_data2", 32'(tx.TX_DATA), 32'h12);
    tick();
    check("b2b_all_taken", exp_q.size(), 0);
    check("b2b_idle", 32'(tx.TX_VALID), 0);

    // Wrap-around: move the read pointer to 0x1FE with an idle flush.
    FLUSH  = 1'b1;
    WR_PTR = (aw+1)'(10'h1FE);
    tick();
    FLUSH = 1'b0;
    check("wrap_start_ptr", 32'(RD_PTR), 32'h1FE);
    check("wrap_start_empty", 32'(EMPTY), 1);
    addr_log.delete();
    log_en = 1'b1;
    push_rand(4);
    drain(50, 1'b0);
    log_en = 1'b0;
    check("wrap_addr_count", addr_log.size(), 5);
    for (int i = 0; i < 5 && i < addr_log.size(); i++) begin
      e_addr = 9'h1FE + 9'(i);
      check("wrap_addr", 32'(addr_log[i]), 32'(e_addr));
    end

    // Full buffer: 512 bytes committed at once, drained with random readiness.
    PAUSE       = 1'b1;
    tx.TX_READY = 1'b0;
    push_rand(depth);
    tick();
    check("full_level", 32'(LEVEL), depth);
    check("full_not_empty", 32'(EMPTY), 0);
    check("full_paused", 32'(tx.TX_VALID), 0);
    drain(3000, 1'b1);

    // Flush while a byte is offered but not yet accepted.
    tx.TX_READY = 1'b0;
    push_val(8'h55);
    push_rand(9);
    tick();
    check("fl_valid", 32'(tx.TX_VALID), 1);
    check("fl_data", 32'(tx.TX_DATA), 32'h55);
    FLUSH = 1'b1;
    keep = exp_q[0];
    exp_q.delete();
    exp_q.push_back(keep);
    tick();
    FLUSH = 1'b0;
    tick();
    tick();
    tx.TX_READY = 1'b1;
    repeat (6) tick();
    check("fl_delivered", exp_q.size(), 0);
    check("fl_rd_ptr", 32'(RD_PTR), 32'(WR_PTR));
    check("fl_empty", 32'(EMPTY), 1);
    check("fl_no_valid", 32'(tx.TX_VALID), 0);

    // Bytes committed in the flush cycle are discarded too.
    push_rand(3);
    FLUSH = 1'b1;
    exp_q.delete();
    tick();
    FLUSH = 1'b0;
    repeat (3) tick();
    check("flc_rd_ptr", 32'(RD_PTR), 32'(WR_PTR));
    check("flc_empty", 32'(EMPTY), 1);

    // Pause holds off new bytes; release delivers them in order.
    PAUSE = 1'b1;
    push_rand(4);
    repeat (5) tick();
    check("pause_valid", 32'(tx.TX_VALID), 0);
    check("pause_rd_ptr", 32'(RD_PTR), 32'(WR_PTR - (aw+1)'(4)));
    check("pause_level", 32'(LEVEL), 4);
    drain(50, 1'b0);

    // Random traffic: commits, pauses and backpressure mixed.
    for (int c = 0; c < 400; c++) begin
      PAUSE       = ($urandom_range(0, 4) == 0);
      tx.TX_READY = ($urandom_range(0, 3) != 0);
      if (exp_q.size() < 400) begin
        k = int'($urandom_range(0, 2));
        push_rand(k);
      end
      tick();
    end
    drain(3000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
